// File: rtl/eth_arb_pkg.sv
// Shared types and arbitration helpers for the frame-atomic AXI-Stream arbiter.
//   arb_state_t : arbiter FSM states
//   rr_pick     : round-robin winner, searching upward from last+1 with wrap
//   prio_pick   : fixed-priority winner, lowest index wins
// Request vectors are zero-extended to MaxPorts so one function body serves
// every legal port count.
package eth_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_PASS, ARB_DROP} arb_state_t;

    localparam int unsigned MaxPorts = 16;
    localparam int unsigned PortIdxW = 4;

    function automatic logic [PortIdxW-1:0] rr_pick(
        input logic [MaxPorts-1:0] req,
        input logic [PortIdxW-1:0] last,
        input int unsigned         n_ports
    );
        logic [PortIdxW-1:0] pick;
        logic                found;
        int unsigned         idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MaxPorts; k++) begin
            idx = (32'(last) + k) % n_ports;
            if (!found && (k <= n_ports) && req[idx]) begin
                pick  = PortIdxW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PortIdxW-1:0] prio_pick(input logic [MaxPorts-1:0] req);
        logic [PortIdxW-1:0] pick;
        pick = '0;
        // Descending scan: the last hit, i.e. the lowest index, wins.
        for (int i = MaxPorts - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick = PortIdxW'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice.
//   s_*  : upstream beat (data, keep, last, user) with valid/ready
//   m_*  : registered downstream beat with valid/ready
// s_ready comes straight from a flop (skid entry empty), so upstream ready
// never depends combinationally on m_ready. The skid entry catches the one
// beat that can arrive while the output register is stalled.
module axis_skid_reg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned KEEP_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [KEEP_WIDTH-1:0] s_keep,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic                  s_user,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [KEEP_WIDTH-1:0] m_keep,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_user
);

    localparam int unsigned PayloadW = DATA_WIDTH + KEEP_WIDTH + 2;

    logic [PayloadW-1:0] out_q, out_d;
    logic [PayloadW-1:0] skid_q, skid_d;
    logic                out_valid_q, out_valid_d;
    logic                skid_valid_q, skid_valid_d;
    logic [PayloadW-1:0] in_payload;
    logic                s_fire;

    assign in_payload = {s_data, s_keep, s_last, s_user};
    assign s_ready    = ~skid_valid_q;
    assign s_fire     = s_valid & s_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (m_ready || !out_valid_q) begin
            // Output register drains (or is empty): refill from skid first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = s_fire;
                if (s_fire) begin
                    out_d = in_payload;
                end
            end
        end else if (s_fire) begin
            skid_d       = in_payload;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign {m_data, m_keep, m_last, m_user} = out_q;
    assign m_valid = out_valid_q;

endmodule

// File: rtl/eth_axis_frame_arb_mux.sv
// N-port frame-atomic AXI-Stream arbiter feeding a single MAC TX stream.
//   s_axis_*    : N client streams, port i at slice i of each bus
//   m_axis_*    : registered output stream towards the MAC
//   grant_port  : index of the current / most recently granted port
//   busy        : arbiter is holding a grant (not idle)
//   trunc_pulse : one-cycle pulse for every frame cut at MAX_BEATS
// A grant is held for a whole frame. Frames longer than MAX_BEATS are cut:
// beat MAX_BEATS leaves with tlast=1/tuser=1 and the rest of the source frame
// is swallowed until its own tlast.
module eth_axis_frame_arb_mux
    import eth_arb_pkg::*;
#(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter string       ARB_MODE   = "RR",
    parameter int unsigned MAX_BEATS  = 1518,
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned GrantW     = $clog2(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [N_PORTS-1:0]            s_axis_tvalid,
    output logic [N_PORTS-1:0]            s_axis_tready,
    input  logic [N_PORTS-1:0]            s_axis_tlast,
    input  logic [N_PORTS-1:0]            s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [GrantW-1:0]             grant_port,
    output logic                          busy,
    output logic                          trunc_pulse
);

    localparam bit                UsePrio = (ARB_MODE == "PRIO");
    localparam int unsigned       CntW    = $clog2(MAX_BEATS + 1);
    localparam logic [CntW-1:0]   LastCnt = CntW'(MAX_BEATS - 1);

    arb_state_t          state_q, state_d;
    logic [GrantW-1:0]   grant_q, grant_d;
    logic [GrantW-1:0]   last_grant_q, last_grant_d;
    logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
    logic                trunc_pulse_q, trunc_pulse_d;

    logic [MaxPorts-1:0]   req_ext;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_user;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  trunc_now;
    logic                  skid_valid;
    logic                  skid_ready;

    assign req_ext = MaxPorts'(s_axis_tvalid);

    // N:1 mux driven only by the held grant; other ports are never looked at.
    always_comb begin
        sel_valid = s_axis_tvalid[grant_q];
        sel_last  = s_axis_tlast[grant_q];
        sel_user  = s_axis_tuser[grant_q];
        sel_data  = s_axis_tdata[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[int'(grant_q) * KEEP_WIDTH +: KEEP_WIDTH];
    end

    // Beat MAX_BEATS without its own tlast is the truncation point.
    assign trunc_now = (beat_cnt_q == LastCnt) && !sel_last;

    always_comb begin
        s_axis_tready = '0;
        skid_valid    = 1'b0;
        case (state_q)
            ARB_PASS: begin
                s_axis_tready[grant_q] = skid_ready;
                skid_valid             = sel_valid;
            end
            ARB_DROP: begin
                s_axis_tready[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        trunc_pulse_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|s_axis_tvalid) begin
                    if (UsePrio) begin
                        grant_d = GrantW'(prio_pick(req_ext));
                    end else begin
                        grant_d = GrantW'(rr_pick(req_ext, PortIdxW'(last_grant_q), N_PORTS));
                    end
                    beat_cnt_d = '0;
                    state_d    = ARB_PASS;
                end
            end
            ARB_PASS: begin
                if (sel_valid && skid_ready) begin
                    if (sel_last) begin
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        state_d      = ARB_IDLE;
                    end else if (trunc_now) begin
                        trunc_pulse_d = 1'b1;
                        beat_cnt_d    = '0;
                        state_d       = ARB_DROP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                    end
                end
            end
            ARB_DROP: begin
                if (sel_valid && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            last_grant_q  <= GrantW'(N_PORTS - 1);
            beat_cnt_q    <= '0;
            trunc_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
            trunc_pulse_q <= trunc_pulse_d;
        end
    end

    axis_skid_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  (sel_data),
        .s_keep  (sel_keep),
        .s_valid (skid_valid),
        .s_ready (skid_ready),
        .s_last  (sel_last | trunc_now),
        .s_user  (sel_user | trunc_now),
        .m_data  (m_axis_tdata),
        .m_keep  (m_axis_tkeep),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_last  (m_axis_tlast),
        .m_user  (m_axis_tuser)
    );

    assign grant_port  = grant_q;
    assign busy        = (state_q != ARB_IDLE);
    assign trunc_pulse = trunc_pulse_q;

endmodule
